// File: rtl/gf180_ram_pkg.sv
// Shared types and constants for the 64x8 GF180 SRAM controller.
// Pin bundle helpers keep the macro's active-low encoding in one place.
package gf180_ram_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_WORDS  = 1 << RAM_ADDR_W;
  localparam int RSP_DEPTH  = 3;
  localparam int PTR_W      = $clog2(RSP_DEPTH);
  localparam int CNT_W      = $clog2(RSP_DEPTH + 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic                  cen;
    logic                  gwen;
    logic [RAM_DATA_W-1:0] wen;
    logic [RAM_ADDR_W-1:0] a;
    logic [RAM_DATA_W-1:0] d;
  } ram_pins_t;

  localparam ram_pins_t PINS_IDLE = '{
    cen:  1'b1,
    gwen: 1'b1,
    wen:  '1,
    a:    '0,
    d:    '0
  };

  function automatic ram_pins_t pins_write(
    input logic [RAM_ADDR_W-1:0] a,
    input logic [RAM_DATA_W-1:0] d,
    input logic [RAM_DATA_W-1:0] m
  );
    ram_pins_t p;
    p.cen  = 1'b0;
    p.gwen = 1'b0;
    p.wen  = ~m;
    p.a    = a;
    p.d    = d;
    return p;
  endfunction

  function automatic ram_pins_t pins_read(
    input logic [RAM_ADDR_W-1:0] a
  );
    ram_pins_t p;
    p.cen  = 1'b0;
    p.gwen = 1'b1;
    p.wen  = '1;
    p.a    = a;
    p.d    = '0;
    return p;
  endfunction

endpackage

// File: rtl/gf180_ram_rsp_fifo.sv
// In-order read response queue with occupancy count.
// Push and pop on the same edge leave the count unchanged.
module gf180_ram_rsp_fifo
  import gf180_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [RAM_DATA_W-1:0] push_data,
  input  logic                  pop,
  output logic [RAM_DATA_W-1:0] head,
  output logic [CNT_W-1:0]      count
);

  logic [RAM_DATA_W-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic                  full;

  function automatic logic [PTR_W-1:0] bump(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(RSP_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/gf180_ram_64x8_ctrl.sv
// Initiator-side controller for one 64x8 GF180 SRAM wrapper.
// Zero-fills the array after reset, then serves masked writes and queued reads.
module gf180_ram_64x8_ctrl
  import gf180_ram_pkg::*;
#(
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [RAM_DATA_W-1:0] INIT_VALUE    = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [RAM_ADDR_W-1:0] req_addr,
  input  logic [RAM_DATA_W-1:0] req_wdata,
  input  logic [RAM_DATA_W-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RAM_DATA_W-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  ram_CEN,
  output logic                  ram_GWEN,
  output logic [RAM_DATA_W-1:0] ram_WEN,
  output logic [RAM_ADDR_W-1:0] ram_A,
  output logic [RAM_DATA_W-1:0] ram_D,
  input  logic [RAM_DATA_W-1:0] ram_Q
);

  state_t                state_q;
  state_t                state_d;
  logic [RAM_ADDR_W-1:0] init_cnt_q;
  logic [RAM_ADDR_W-1:0] init_cnt_d;
  logic                  init_done_q;
  logic                  init_done_d;
  logic                  rd_pend_q;
  logic                  req_fire;
  logic                  rd_fire;
  logic [CNT_W-1:0]      fifo_count;
  logic [RAM_DATA_W-1:0] fifo_head;
  logic [CNT_W:0]        occ;
  ram_pins_t             pins;

  // Reads in flight count against queue space so the FIFO can never overflow.
  assign occ       = {1'b0, fifo_count} + (CNT_W + 1)'(rd_pend_q);
  assign req_ready = !RST && init_done_q
                  && (occ <= (CNT_W + 1)'(RSP_DEPTH - 1));
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_we;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_fire;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    pins        = PINS_IDLE;
    unique case (state_q)
      ST_INIT: begin
        if (!INIT_ON_RESET) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          pins       = pins_write(init_cnt_q, INIT_VALUE, '1);
          init_cnt_d = init_cnt_q + RAM_ADDR_W'(1);
          if (init_cnt_q == RAM_ADDR_W'(RAM_WORDS - 1)) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (req_fire) begin
          pins = req_we ? pins_write(req_addr, req_wdata, req_wmask)
                        : pins_read(req_addr);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    // Macro stays quiet while reset is held, even mid-sweep.
    if (RST) begin
      pins = PINS_IDLE;
    end
  end

  assign ram_CEN  = pins.cen;
  assign ram_GWEN = pins.gwen;
  assign ram_WEN  = pins.wen;
  assign ram_A    = pins.a;
  assign ram_D    = pins.d;

  gf180_ram_rsp_fifo u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rd_pend_q),
    .push_data (ram_Q),
    .pop       (rsp_valid && rsp_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_rdata = rsp_valid ? fifo_head : '0;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_gf180_ram_64x8_ctrl.sv
// Bench for gf180_ram_64x8_ctrl with a behavioural 64x8 macro model.
// Read expectations come from a reference array and flow through a queue.
module tb_gf180_ram_64x8_ctrl;

  logic       CLK;
  logic       RST;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] req_wmask;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       ram_CEN;
  logic       ram_GWEN;
  logic [7:0] ram_WEN;
  logic [5:0] ram_A;
  logic [7:0] ram_D;
  logic [7:0] ram_Q;

  logic [7:0] sram    [64];
  logic [7:0] ref_mem [64];
  logic [7:0] exp_q   [$];
  int n_cmp = 0;
  int n_bad = 0;

  gf180_ram_64x8_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .ram_CEN   (ram_CEN),
    .ram_GWEN  (ram_GWEN),
    .ram_WEN   (ram_WEN),
    .ram_A     (ram_A),
    .ram_D     (ram_D),
    .ram_Q     (ram_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro model: WEN bit low writes that bit; reads update Q at the edge.
  always @(posedge CLK) begin
    if (!ram_CEN) begin
      if (!ram_GWEN)
        sram[ram_A] <= (sram[ram_A] & ram_WEN) | (ram_D & ~ram_WEN);
      else
        ram_Q <= sram[ram_A];
    end
  end

  task automatic test_reset;
    RST = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if ({req_ready, rsp_valid, init_done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {req_ready, rsp_valid, init_done}); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", rsp_rdata); end
    n_cmp++; if ({ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D} !== {1'b1, 1'b1, 8'hFF, 6'h00, 8'h00}) begin n_bad++; $display("FAIL reset_pins got %b%b %h %h %h", ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D); end
  endtask

  // Entered at a negedge with RST just released.
  task automatic test_init;
    for (int i = 0; i < 64; i++) begin
      #1;
      n_cmp++; if ({ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D} !== {1'b0, 1'b0, 8'h00, 6'(i), 8'h00}) begin n_bad++; $display("FAIL init_pins[%0d] got %b%b %h %h %h", i, ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D); end
      n_cmp++; if ({req_ready, init_done, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL init_flags[%0d] got %b want 000", i, {req_ready, init_done, rsp_valid}); end
      @(negedge CLK);
    end
    n_cmp++; if ({init_done, req_ready} !== 2'b11) begin n_bad++; $display("FAIL init_done got %b want 11", {init_done, req_ready}); end
    n_cmp++; if (ram_CEN !== 1'b1) begin n_bad++; $display("FAIL init_end_cen got %b want 1", ram_CEN); end
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic test_write_read;
    logic [7:0] e;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h3F;
    req_wdata = 8'hA5; req_wmask = 8'hFF; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready got %b want 1", req_ready); end
    n_cmp++; if ({ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D} !== {1'b0, 1'b0, 8'h00, 6'h3F, 8'hA5}) begin n_bad++; $display("FAIL wr_pins got %b%b %h %h %h", ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D); end
    if (req_ready) ref_mem[63] = (ref_mem[63] & ~req_wmask) | (req_wdata & req_wmask);
    @(negedge CLK);
    req_we = 1'b0;
    #1;
    n_cmp++; if ({ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D} !== {1'b0, 1'b1, 8'hFF, 6'h3F, 8'h00}) begin n_bad++; $display("FAIL rd_pins got %b%b %h %h %h", ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D); end
    if (req_ready) exp_q.push_back(ref_mem[63]);
    @(negedge CLK);
    req_valid = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_early got %b want 0", rsp_valid); end
    n_cmp++; if ({ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D} !== {1'b1, 1'b1, 8'hFF, 6'h00, 8'h00}) begin n_bad++; $display("FAIL idle_pins got %b%b %h %h %h", ram_CEN, ram_GWEN, ram_WEN, ram_A, ram_D); end
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_latency got %b want 1", rsp_valid); end
    if (rsp_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (rsp_rdata !== e) begin n_bad++; $display("FAIL rd_data got %h want %h", rsp_rdata, e); end
      n_cmp++; if (rsp_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_a5 got %h want a5", rsp_rdata); end
    end
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_popped got %b want 0", rsp_valid); end
  endtask

  task automatic test_masked_write;
    logic [7:0] e;
    int c;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h3F;
    req_wdata = 8'h3C; req_wmask = 8'h0F; rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({ram_CEN, ram_GWEN, ram_WEN, ram_D} !== {1'b0, 1'b0, 8'hF0, 8'h3C}) begin n_bad++; $display("FAIL mask_pins got %b%b %h %h", ram_CEN, ram_GWEN, ram_WEN, ram_D); end
    if (req_ready) ref_mem[63] = (ref_mem[63] & ~req_wmask) | (req_wdata & req_wmask);
    @(negedge CLK);
    req_we = 1'b0;
    #1;
    if (req_ready) exp_q.push_back(ref_mem[63]);
    @(negedge CLK);
    req_valid = 1'b0;
    c = 0;
    while (!rsp_valid && c < 5) begin @(negedge CLK); c++; end
    n_cmp++;
    if (!rsp_valid || exp_q.size() == 0) begin
      n_bad++; $display("FAIL mask_rsp got valid=%b want 1", rsp_valid);
    end else begin
      e = exp_q.pop_front();
      if (rsp_rdata !== e || rsp_rdata !== 8'hAC) begin n_bad++; $display("FAIL mask_data got %h want %h", rsp_rdata, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    int issued = 0;
    int got = 0;
    int last = -1;
    logic [7:0] e;
    for (int i = 0; i < 64; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'(i);
      req_wdata = 8'(i * 7 + 3); req_wmask = 8'hFF; rsp_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got %b want 1", i, req_ready); end
      if (req_ready) ref_mem[i] = req_wdata;
      @(negedge CLK);
    end
    for (int c = 0; c < 90 && got < 64; c++) begin
      req_valid = (issued < 64); req_we = 1'b0; req_addr = 6'(issued);
      #1;
      if (issued < 64) begin
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", issued, req_ready); end
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra got %h want none", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_rdata !== e) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", got, rsp_rdata, e); end
        end
        if (last >= 0 && c != last + 1) begin n_bad++; $display("FAIL b2b_gap at cycle %0d want %0d", c, last + 1); end
        last = c;
        got++;
      end
      if (req_valid && req_ready) begin exp_q.push_back(ref_mem[issued]); issued++; end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    n_cmp++; if (got != 64) begin n_bad++; $display("FAIL b2b_count got %0d want 64", got); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    int drained = 0;
    logic [7:0] e;
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(10 + acc);
      #1;
      if (req_ready) begin exp_q.push_back(ref_mem[10 + acc]); acc++; end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL bp_accepted got %0d want 3", acc); end
    n_cmp++; if ({req_ready, rsp_valid} !== 2'b01) begin n_bad++; $display("FAIL bp_stall got %b want 01", {req_ready, rsp_valid}); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rsp_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra got %h want none", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_rdata !== e) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", drained, rsp_rdata, e); end
        end
        drained++;
      end
      @(negedge CLK);
    end
    n_cmp++; if (drained != 3) begin n_bad++; $display("FAIL bp_drained got %0d want 3", drained); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back got %b want 1", req_ready); end
  endtask

  task automatic test_reset_mid;
    int acc = 0;
    int c = 0;
    logic [7:0] e;
    rsp_ready = 1'b0;
    while (acc < 3 && c < 10) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(20 + acc);
      #1;
      if (req_ready) acc++;
      @(negedge CLK);
      c++;
    end
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1 || acc != 3) begin n_bad++; $display("FAIL rm_setup got valid=%b acc=%0d want 1/3", rsp_valid, acc); end
    RST = 1'b1;
    exp_q.delete();
    #1;
    n_cmp++; if ({ram_CEN, req_ready} !== 2'b10) begin n_bad++; $display("FAIL rm_pins got %b want 10", {ram_CEN, req_ready}); end
    @(negedge CLK);
    n_cmp++; if ({rsp_valid, init_done} !== 2'b00) begin n_bad++; $display("FAIL rm_flush got %b want 00", {rsp_valid, init_done}); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rm_rdata got %h want 00", rsp_rdata); end
    RST = 1'b0;
    rsp_ready = 1'b1;
    test_init();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h15;
    #1;
    if (req_ready) exp_q.push_back(ref_mem[21]);
    @(negedge CLK);
    req_valid = 1'b0;
    c = 0;
    while (!rsp_valid && c < 5) begin @(negedge CLK); c++; end
    n_cmp++;
    if (!rsp_valid || exp_q.size() == 0) begin
      n_bad++; $display("FAIL rm_read got valid=%b want 1", rsp_valid);
    end else begin
      e = exp_q.pop_front();
      if (rsp_rdata !== e) begin n_bad++; $display("FAIL rm_read_data got %h want %h", rsp_rdata, e); end
    end
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stale got %b want 0", rsp_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    RST = 1'b0;
    test_init();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180_ram_64x8_ctrl.md
# gf180_ram_64x8_ctrl

Initiator-side controller for the 64x8 GF180 SRAM wrapper. Accepts read/write requests on a valid/ready port, drives the macro's active-low pins (CEN, GWEN, WEN) plus A and D, captures Q into an ordered response queue, and zero-fills the array after reset. Sits between the core's data-memory path and one `gf180_ram_64x8_wrapper` instance.

## Interface
Parameters:
- `INIT_ON_RESET`, 1: sweep-write `INIT_VALUE` to all 64 words after reset.
- `INIT_VALUE`, 8'h00: fill value.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on the edge where `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  6  word address.
- `req_wdata`  in  8  write data.
- `req_wmask`  in  8  per-bit write enable, 1 = write bit.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the head on the edge where `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  8  read data, head of queue.
- `init_done`  out  1  initialisation sweep finished.
- `ram_CEN`  out  1  to macro CEN, active low.
- `ram_GWEN`  out  1  to macro GWEN, 0 = write.
- `ram_WEN`  out  8  to macro WEN, active-low bit mask.
- `ram_A`  out  6  to macro A.
- `ram_D`  out  8  to macro D.
- `ram_Q`  in  8  from macro Q.

## Operation
- FSM states: `ST_INIT`, `ST_RUN`. `RST` forces `ST_INIT`, init address 0.
- `ST_INIT` with `INIT_ON_RESET=1`:
  - One write per cycle: `ram_CEN=0`, `ram_GWEN=0`, `ram_WEN=8'h00`, `ram_A`=counter, `ram_D=INIT_VALUE`.
  - Counter runs 0..63. After address 63 is issued, go to `ST_RUN` and set `init_done=1`.
- `ST_INIT` with `INIT_ON_RESET=0`: go straight to `ST_RUN`. `init_done` is 1 on the first cycle after `RST` deasserts.
- `ST_RUN`:
  - Macro pins are combinational from the request during a fire. `ram_CEN=0`, `ram_A=req_addr`.
  - Write fire: `ram_GWEN=0`, `ram_WEN=~req_wmask`, `ram_D=req_wdata`.
  - Read fire: `ram_GWEN=1`, `ram_WEN=8'hFF`, `ram_D=0`.
  - Write with `req_wmask=0` still pulses `CEN`; memory is unchanged. Writes produce no response.
- Idle pins (no fire, not init): `ram_CEN=1`, `ram_GWEN=1`, `ram_WEN=8'hFF`, `ram_A=0`, `ram_D=0`.
- Read tracking:
  - `rd_pend` is set on a read fire.
  - On the following edge, `ram_Q` is pushed into a 3-entry in-order response FIFO; `rd_pend` clears unless another read fired.
- Flow control:
  - `req_ready = init_done && (fifo_count + rd_pend) <= 2`.
  - `req_ready` has no combinational dependence on `req_valid`, `req_we` or `rsp_ready`.
  - Writes obey the same `req_ready`.
- FIFO:
  - `rsp_valid = fifo_count != 0`; `rsp_rdata` = head.
  - Push and pop on the same edge leave the count unchanged. Overflow is structurally impossible under the ready rule.
- Reset mid-operation: FIFO emptied, `rd_pend` cleared, in-flight read discarded, init sweep restarts.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `init_done=0`, `ram_CEN=1`, `ram_GWEN=1`, `ram_WEN=8'hFF`, `ram_A=0`, `ram_D=0`.
- Init duration: 64 cycles. With `RST` low from edge E0, `init_done` and `req_ready` go high after edge E64.
- Read latency: read accepted at edge N gives `rsp_valid` high after edge N+1 (`ram_Q` captured at N+1).
- Throughput:
  - One request per cycle sustained while `rsp_ready=1`.
  - With `rsp_ready=0`, at most 3 reads are outstanding, then `req_ready=0`.
- Read after write to the same address on consecutive cycles returns the new data.

## Structure
- Package `gf180_ram_pkg`: `RAM_ADDR_W=6`, `RAM_DATA_W=8`, `RSP_DEPTH=3`, state enum (`ST_INIT`, `ST_RUN`).
- Sub-module `gf180_ram_rsp_fifo`: 3-entry synchronous FIFO with count output. The FSM, init counter and pin muxing stay in the top module.

## Test plan
- Reset release, `INIT_ON_RESET=1`:
  - Expect exactly 64 write cycles, `ram_A` 0..63, `ram_D=00`, `ram_WEN=00`.
  - `init_done` high after the 64th edge, `req_ready` low throughout init.
- Write 0x3F←0xA5 (mask FF), then read 0x3F next cycle → `rsp_rdata=0xA5`, `rsp_valid` one edge after the read is accepted.
- Masked write, data 0x3C mask 0x0F, over 0xA5 → read returns 0xAC. Confirm `ram_WEN=0xF0` during the write.
- 64 back-to-back reads with `rsp_ready=1` → `req_ready` never drops, 64 responses on consecutive cycles, in address order.
- `rsp_ready=0` with continuous reads:
  - Exactly 3 accepted, then `req_ready=0`.
  - Raising `rsp_ready` drains 3 responses in order; `req_ready` returns.
- `RST` pulsed with 2 responses queued and 1 read in flight → `rsp_valid=0` after the reset edge, no stale data delivered, full 64-cycle init repeats.
